// File: rtl/uart_rx_drain_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_drain_ctrl_pkg
//  Description : Shared types and constants for the UART RX drain controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_drain_ctrl_pkg;

    localparam int c_DATA_WIDTH_DEF = 8;
    localparam int c_WORD_BYTES_DEF = 4;
    localparam int c_TO_WIDTH_DEF   = 16;

    typedef enum logic [1:0] {
        DR_IDLE = 2'd0,
        DR_REQ  = 2'd1,
        DR_CAP  = 2'd2,
        DR_OUT  = 2'd3
    } drain_state_t;

    // Width of a counter holding 0..WORD_BYTES inclusive.
    function automatic int cnt_width(input int word_bytes);
        return $clog2(word_bytes + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_drain_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_drain_ctrl_if
//  Description : Config, FIFO read port and packed-word stream of the drain ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_drain_ctrl_if
    import uart_rx_drain_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEF,
    parameter int WORD_BYTES = c_WORD_BYTES_DEF,
    parameter int TO_WIDTH   = c_TO_WIDTH_DEF
);

    localparam int c_CNT_W = cnt_width(WORD_BYTES);

    logic                             cfg_enable_i;
    logic [TO_WIDTH-1:0]              cfg_timeout_i;
    logic                             cfg_flush_i;
    logic                             cfg_irq_en_i;
    logic                             fifo_empty_i;
    logic [DATA_WIDTH-1:0]            fifo_rdata_i;
    logic                             fifo_re_o;
    logic [DATA_WIDTH*WORD_BYTES-1:0] word_data_o;
    logic [c_CNT_W-1:0]               word_bytes_o;
    logic                             word_valid_o;
    logic                             word_ready_i;
    logic                             timeout_o;
    logic                             irq_o;

    modport master (
        input  cfg_enable_i, cfg_timeout_i, cfg_flush_i, cfg_irq_en_i,
        input  fifo_empty_i, fifo_rdata_i, word_ready_i,
        output fifo_re_o, word_data_o, word_bytes_o, word_valid_o,
        output timeout_o, irq_o
    );

    modport slave (
        output cfg_enable_i, cfg_timeout_i, cfg_flush_i, cfg_irq_en_i,
        output fifo_empty_i, fifo_rdata_i, word_ready_i,
        input  fifo_re_o, word_data_o, word_bytes_o, word_valid_o,
        input  timeout_o, irq_o
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_drain_ctrl_idle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_drain_ctrl_idle_timer
//  Description : Saturating line-idle counter compared live against the config.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_drain_ctrl_idle_timer #(
    parameter int TO_WIDTH = 16
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESETN,
    input  logic                i_clear,
    input  logic                i_enable,
    input  logic [TO_WIDTH-1:0] i_timeout,
    output logic                o_expired
);

    logic [TO_WIDTH-1:0] r_count;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count < i_timeout)) begin
            r_count <= r_count + TO_WIDTH'(1);
        end
    end

    // >= so that lowering the config below the running count fires at once.
    assign o_expired = (i_timeout != '0) && (r_count >= i_timeout);

endmodule
`default_nettype wire

// File: rtl/uart_rx_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_drain_ctrl
//  Description : Pops UART RX FIFO bytes, packs them little-endian into words,
//                flushes partial words on idle timeout or software flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_drain_ctrl
    import uart_rx_drain_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEF,
    parameter int WORD_BYTES = c_WORD_BYTES_DEF,
    parameter int TO_WIDTH   = c_TO_WIDTH_DEF
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    uart_rx_drain_ctrl_if.master bus
);

    localparam int                 c_CNT_W = cnt_width(WORD_BYTES);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WORD_BYTES - 1);

    drain_state_t                     r_state;
    drain_state_t                     w_next_state;
    logic [c_CNT_W-1:0]               r_byte_cnt;
    logic                             r_flush_pend;
    logic [DATA_WIDTH*WORD_BYTES-1:0] w_word;
    logic                             w_has_bytes;
    logic                             w_flush_req;
    logic                             w_expired;
    logic                             w_valid;
    logic                             w_accept;
    logic                             w_fifo_re;
    logic                             w_timeout_pulse;

    assign w_has_bytes = (r_byte_cnt != '0);
    assign w_flush_req = (bus.cfg_flush_i | r_flush_pend) & w_has_bytes;
    assign w_valid     = (r_state == DR_OUT);
    assign w_accept    = w_valid & bus.word_ready_i;

    uart_rx_drain_ctrl_idle_timer #(
        .TO_WIDTH (TO_WIDTH)
    ) u_idle_timer (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .i_clear       ((r_state == DR_CAP) | w_accept | ~w_has_bytes),
        .i_enable      ((r_state == DR_IDLE) & w_has_bytes),
        .i_timeout     (bus.cfg_timeout_i),
        .o_expired     (w_expired)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= DR_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Flush beats timeout, so a coincident pair yields one word and no pulse.
    always_comb begin
        w_next_state    = r_state;
        w_fifo_re       = 1'b0;
        w_timeout_pulse = 1'b0;
        case (r_state)
            DR_IDLE: begin
                if (w_flush_req) begin
                    w_next_state = DR_OUT;
                end else if (w_expired && w_has_bytes) begin
                    w_next_state    = DR_OUT;
                    w_timeout_pulse = 1'b1;
                end else if (bus.cfg_enable_i && !bus.fifo_empty_i) begin
                    w_next_state = DR_REQ;
                end
            end
            DR_REQ: begin
                w_fifo_re    = 1'b1;
                w_next_state = DR_CAP;
            end
            DR_CAP: begin
                w_next_state = (r_byte_cnt == c_LAST) ? DR_OUT : DR_IDLE;
            end
            DR_OUT: begin
                if (bus.word_ready_i) begin
                    w_next_state = DR_IDLE;
                end
            end
            default: w_next_state = DR_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_byte_cnt   <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            if (r_state == DR_CAP) begin
                r_byte_cnt <= r_byte_cnt + c_CNT_W'(1);
            end else if (w_accept) begin
                r_byte_cnt <= '0;
            end
            // A flush arriving mid-pop is held until the FSM is back in IDLE.
            if ((r_state == DR_REQ) || (r_state == DR_CAP)) begin
                r_flush_pend <= r_flush_pend | bus.cfg_flush_i;
            end else begin
                r_flush_pend <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0] r_lane;

        always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) begin
                r_lane <= '0;
            end else if (w_accept) begin
                r_lane <= '0;
            end else if ((r_state == DR_CAP) && (r_byte_cnt == c_CNT_W'(gi))) begin
                r_lane <= bus.fifo_rdata_i;
            end
        end

        assign w_word[gi*DATA_WIDTH +: DATA_WIDTH] = r_lane;
    end

    assign bus.fifo_re_o    = w_fifo_re;
    assign bus.word_data_o  = w_word;
    assign bus.word_valid_o = w_valid;
    assign bus.word_bytes_o = w_valid ? r_byte_cnt : '0;
    assign bus.timeout_o    = w_timeout_pulse;
    assign bus.irq_o        = w_valid & bus.cfg_irq_en_i;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_drain_ctrl
//  Description : Directed, table-driven self-checking bench for the drain ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_drain_ctrl;

    localparam int DW  = 8;
    localparam int WB  = 4;
    localparam int TOW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_rx_drain_ctrl_if #(.DATA_WIDTH(DW), .WORD_BYTES(WB), .TO_WIDTH(TOW)) bus ();

    uart_rx_drain_ctrl #(
        .DATA_WIDTH (DW),
        .WORD_BYTES (WB),
        .TO_WIDTH   (TOW)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .bus           (bus)
    );

    // FIFO model: data appears on fifo_rdata_i one cycle after the pop strobe.
    logic [7:0] fifo_mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign bus.fifo_empty_i = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_re_o && (rd_ptr != wr_ptr)) begin
            bus.fifo_rdata_i <= fifo_mem[rd_ptr];
            rd_ptr           <= rd_ptr + 1;
        end
    end

    int          mon_words  = 0;
    int          mon_re     = 0;
    int          mon_to     = 0;
    int          mon_re_out = 0;
    logic [31:0] mon_data   = '0;
    int          mon_bytes  = 0;

    always @(posedge clk) begin
        if (bus.fifo_re_o) mon_re <= mon_re + 1;
        if (bus.timeout_o) mon_to <= mon_to + 1;
        if (bus.fifo_re_o && bus.word_valid_o) mon_re_out <= mon_re_out + 1;
        if (bus.word_valid_o && bus.word_ready_i) begin
            mon_data  <= bus.word_data_o;
            mon_bytes <= 32'(bus.word_bytes_o);
            mon_words <= mon_words + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr           = wr_ptr + 1;
    endtask

    task automatic pulse_flush();
        bus.cfg_flush_i = 1'b1;
        @(negedge clk);
        bus.cfg_flush_i = 1'b0;
    endtask

    task automatic wait_re(input int target, input string name);
        bit done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (mon_re >= target) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_word(input int target, input int bound, input string name);
        bit done = 1'b0;
        for (int c = 0; c < bound && !done; c++) begin
            @(negedge clk);
            if (mon_words >= target) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_valid(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (bus.word_valid_o) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    typedef struct {
        logic [31:0] data;
        int          n;
        int          to_cfg;
        bit          use_flush;
        logic [31:0] exp_word;
        int          exp_bytes;
        int          exp_to;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w0;
        int          r0;
        int          t0;
        bit          stable;
        logic [31:0] d;
        logic [7:0]  b;

        vecs[0] = '{32'h4433_2211, 4, 0,   1'b0, 32'h4433_2211, 4, 0};
        vecs[1] = '{32'hFFFF_BBAA, 2, 100, 1'b0, 32'h0000_BBAA, 2, 1};
        vecs[2] = '{32'hEEEE_EE5A, 1, 0,   1'b1, 32'h0000_005A, 1, 0};
        vecs[3] = '{32'h7703_0201, 3, 5,   1'b0, 32'h0003_0201, 3, 1};
        vecs[4] = '{32'hEFBE_ADDE, 4, 5,   1'b0, 32'hEFBE_ADDE, 4, 0};

        bus.cfg_enable_i  = 1'b1;
        bus.cfg_timeout_i = '0;
        bus.cfg_flush_i   = 1'b0;
        bus.cfg_irq_en_i  = 1'b1;
        bus.word_ready_i  = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.word_valid_o), 32'd0);
        check("rst_bytes", 32'(bus.word_bytes_o), 32'd0);
        check("rst_data",  bus.word_data_o,       32'd0);
        check("rst_re",    32'(bus.fifo_re_o),    32'd0);
        check("rst_to",    32'(bus.timeout_o),    32'd0);
        check("rst_irq",   32'(bus.irq_o),        32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            bus.cfg_timeout_i = 16'(vecs[i].to_cfg);
            w0 = mon_words;
            r0 = mon_re;
            t0 = mon_to;
            d  = vecs[i].data;
            for (int k = 0; k < vecs[i].n; k++) begin
                b = d[8*k +: 8];
                push(b);
            end
            if (vecs[i].use_flush) begin
                wait_re(r0 + vecs[i].n, $sformatf("v%0d_pops", i));
                repeat (2) @(negedge clk);
                pulse_flush();
            end
            wait_word(w0 + 1, 400, $sformatf("v%0d_word_seen", i));
            check($sformatf("v%0d_data", i),  mon_data,              vecs[i].exp_word);
            check($sformatf("v%0d_bytes", i), 32'(mon_bytes),        32'(vecs[i].exp_bytes));
            check($sformatf("v%0d_to", i),    32'(mon_to - t0),      32'(vecs[i].exp_to));
            check($sformatf("v%0d_re", i),    32'(mon_re - r0),      32'(vecs[i].n));
            repeat (3) @(negedge clk);
        end

        // Flush with nothing buffered must not produce a word.
        w0 = mon_words;
        pulse_flush();
        repeat (10) @(negedge clk);
        check("flush_empty_words", 32'(mon_words), 32'(w0));
        check("flush_empty_valid", 32'(bus.word_valid_o), 32'd0);

        // Back-pressure: word held stable, no pops while the word is pending.
        bus.word_ready_i  = 1'b0;
        bus.cfg_timeout_i = 16'd20;
        for (int k = 0; k < 6; k++) push(8'(8'h10 + k));
        wait_valid("bp_valid_seen");
        r0     = mon_re;
        stable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!bus.word_valid_o || bus.word_data_o !== 32'h1312_1110 ||
                bus.word_bytes_o !== 3'd4) stable = 1'b0;
        end
        check("bp_stable",   32'(stable),        32'd1);
        check("bp_no_pop",   32'(mon_re - r0),   32'd0);
        check("bp_re_in_out", 32'(mon_re_out),   32'd0);
        check("bp_irq_on",   32'(bus.irq_o),     32'd1);
        bus.cfg_irq_en_i = 1'b0;
        @(negedge clk);
        check("bp_irq_masked", 32'(bus.irq_o),   32'd0);
        bus.cfg_irq_en_i = 1'b1;
        w0 = mon_words;
        t0 = mon_to;
        bus.word_ready_i = 1'b1;
        wait_word(w0 + 1, 20, "bp_w1_seen");
        check("bp_w1_data",  mon_data,           32'h1312_1110);
        check("bp_w1_bytes", 32'(mon_bytes),     32'd4);
        wait_word(w0 + 2, 300, "bp_w2_seen");
        check("bp_w2_data",  mon_data,           32'h0000_1514);
        check("bp_w2_bytes", 32'(mon_bytes),     32'd2);
        check("bp_w2_to",    32'(mon_to - t0),   32'd1);
        repeat (3) @(negedge clk);

        // Disabled: bytes stay queued; timeout disabled so nothing moves.
        bus.cfg_enable_i  = 1'b0;
        bus.cfg_timeout_i = '0;
        r0 = mon_re;
        w0 = mon_words;
        push(8'h31); push(8'h32); push(8'h33);
        repeat (40) @(negedge clk);
        check("dis_no_pop",   32'(mon_re - r0),  32'd0);
        check("dis_no_valid", 32'(bus.word_valid_o), 32'd0);
        bus.cfg_enable_i = 1'b1;
        wait_re(r0 + 3, "en_pops");
        repeat (2) @(negedge clk);
        pulse_flush();
        wait_word(w0 + 1, 50, "en_word_seen");
        check("en_data",  mon_data,        32'h0033_3231);
        check("en_bytes", 32'(mon_bytes),  32'd3);
        repeat (3) @(negedge clk);

        // Reset while a word is pending.
        bus.word_ready_i = 1'b0;
        w0 = mon_words;
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        wait_valid("rstout_valid_seen");
        check("rstout_irq_before", 32'(bus.irq_o), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstout_valid", 32'(bus.word_valid_o), 32'd0);
        check("rstout_irq",   32'(bus.irq_o),        32'd0);
        check("rstout_bytes", 32'(bus.word_bytes_o), 32'd0);
        bus.word_ready_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstout_data", bus.word_data_o, 32'd0);
        check("rstout_no_word", 32'(mon_words), 32'(w0));
        r0 = mon_re;
        push(8'hC1); push(8'hC2);
        wait_re(r0 + 2, "fresh_pops");
        repeat (2) @(negedge clk);
        pulse_flush();
        wait_word(w0 + 1, 50, "fresh_word_seen");
        check("fresh_data",  mon_data,       32'h0000_C2C1);
        check("fresh_bytes", 32'(mon_bytes), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
